hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencer and HI/LO register file downstream of the divider and multiplier in the MIPS datapath. Accepts DIV/MULT/MTHI/MTLO operations from the control unit and starts the arithmetic unit with a one-cycle pulse. Captures the 64-bit result into HI/LO on completion and serves MFHI/MFLO reads, stalling the pipeline while an operation is in flight. Raises the divide-by-zero exception toward the exception logic.

## Interface
- WIDTH, 32: datapath and HI/LO width.
- TIMEOUT, 40: maximum cycles spent waiting for a done pulse before abort.
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request from control unit.
- op_sel  in  2  0=DIV, 1=MULT, 2=MTHI, 3=MTLO.
- op_a  in  WIDTH  rs operand.
- op_b  in  WIDTH  rt operand.
- rd_en  in  1  MFHI/MFLO request.
- rd_sel  in  1  0=LO, 1=HI.
- rd_data  out  WIDTH  read data; 0 when not (rd_en & !busy).
- stall  out  1  combinational; pipeline must hold the current op/read.
- busy  out  1  state != IDLE.
- DivIn  out  1  divider start pulse.
- MultIn  out  1  multiplier start pulse.
- arith_a, arith_b  out  WIDTH  latched operands to divider/multiplier.
- DivStop, MultStop  in  1  single-cycle done pulses.
- DivZero  in  1  divider-detected divide-by-zero.
- resultHigh, resultLow  in  WIDTH  divider result (HI=remainder, LO=quotient).
- multHigh, multLow  in  WIDTH  multiplier product.
- div_zero_exc  out  1  one-cycle exception pulse.
- timeout_err  out  1  one-cycle abort pulse (only with TIMEOUT enabled).

## Operation
- States: IDLE, DIV_WAIT, MULT_WAIT.
- Reset values: state=IDLE, HI=0, LO=0, DivIn=MultIn=0, arith_a=arith_b=0, div_zero_exc=0, timeout_err=0, timer=0.
- IDLE, op_valid: accept.
  - DIV, op_b==0: no start; state stays IDLE; div_zero_exc pulses; HI/LO unchanged.
  - DIV, op_b!=0: latch operands; DivIn pulses; go to DIV_WAIT.
  - MULT: latch operands; MultIn pulses; go to MULT_WAIT.
  - MTHI/MTLO: HI/LO <= op_a at this edge; stay IDLE.
- DIV_WAIT:
  - DivStop=1 with DivZero=0: HI<=resultHigh, LO<=resultLow; go to IDLE.
  - DivZero=1 (regardless of DivStop): HI/LO unchanged; div_zero_exc pulses; go to IDLE.
- MULT_WAIT:
  - MultStop=1: HI<=multHigh, LO<=multLow; go to IDLE.
  - DivStop/DivZero ignored.
- stall = busy & (op_valid | rd_en). Stalled requests are not consumed; the requester holds them.
- Done pulses arriving in IDLE are ignored.
- Reset asserted mid-operation: immediate return to reset values; the arithmetic unit is not notified, and its late done pulse is ignored in IDLE.

## Timing
- Accept at edge N: DivIn/MultIn high during cycle N+1 only; busy high from N+1.
- Done sampled at edge M: HI/LO valid and busy low from cycle M+1.
- Minimum op-to-read latency is 2 cycles plus the arithmetic latency.
- rd_data is combinational from HI/LO.
- A read in the done cycle stalls; its data is returned in cycle M+1.
- div_zero_exc for op_b==0 is high in cycle N+1.
- MTHI/MTLO data is readable in the next cycle.

## Configuration
- HILO_TIMEOUT_EN defined:
  - An 8-bit timer resets on entering a WAIT state and increments each WAIT cycle.
  - If it reaches TIMEOUT with no done pulse: go to IDLE, pulse timeout_err, HI/LO unchanged.
- Undefined: no timer; WAIT states are held indefinitely; timeout_err is tied to 0.

## Structure
- Shared package hilo_pkg holds:
  - op_sel encodings OP_DIV, OP_MULT, OP_MTHI, OP_MTLO.
  - state enum.
  - WIDTH default.
- Sub-module hilo_regs: the HI/LO register pair with write-enable/select and a combinational read mux.
- Sequencing stays in hilo_ctrl.

## Test plan
- Reset, then MFLO and MFHI → rd_data=0; busy=0.
- DIV a=100, b=7; model DivStop after 33 cycles with HI=2, LO=14 → DivIn single pulse; stall during MFLO; LO=14, HI=2 readable in the cycle after DivStop.
- DIV b=0 → no DivIn; div_zero_exc high exactly 1 cycle; HI/LO keep their prior values.
- MTHI 0xDEADBEEF, then MULT issued while MULT_WAIT is busy → second op stalled until MultStop; HI=multHigh afterwards, overwriting 0xDEADBEEF.
- Reset asserted in DIV_WAIT cycle 10, then a DivStop pulse after reset release → state=IDLE; HI/LO=0; the pulse is ignored.
- With HILO_TIMEOUT_EN: DIV with no DivStop → timeout_err at wait cycle 40; busy low next cycle; HI/LO unchanged.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer: op_sel encodings, FSM states, default width.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_MULT = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_WAIT  = 2'd1,
    MULT_WAIT = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/hilo_ctrl_regs.sv
// HI/LO register pair with independent write enables and a combinational read mux.
module hilo_regs
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_mux
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Capture HI and LO independently so MTHI/MTLO touch only one half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  // Read select: 1 = HI, 0 = LO.
  always_comb begin
    rd_mux = rd_sel ? hi_q : lo_q;
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: starts divider/multiplier, captures results, serves MFHI/MFLO.
// Optional abort timer enabled by defining HILO_TIMEOUT_EN.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = HILO_WIDTH,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic             DivIn,
  output logic             MultIn,
  output logic [WIDTH-1:0] arith_a,
  output logic [WIDTH-1:0] arith_b,
  input  logic             DivStop,
  input  logic             MultStop,
  input  logic             DivZero,
  input  logic [WIDTH-1:0] resultHigh,
  input  logic [WIDTH-1:0] resultLow,
  input  logic [WIDTH-1:0] multHigh,
  input  logic [WIDTH-1:0] multLow,
  output logic             div_zero_exc,
  output logic             timeout_err
);

  hilo_state_t      state;
  hilo_state_t      state_d;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             start_div;
  logic             start_mult;
  logic             exc_d;
  logic             tmo_fire;
  logic [WIDTH-1:0] rd_mux;

  assign busy  = (state != IDLE);
  assign stall = busy & (op_valid | rd_en);

  // Reads are only served while idle; otherwise the bus is held at zero.
  always_comb begin
    rd_data = (rd_en && !busy) ? rd_mux : '0;
  end

`ifdef HILO_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] timer;

  // Abort fires on the edge that would bring the timer to TIMEOUT with no done seen.
  always_comb begin
    tmo_fire = 1'b0;
    if (timer == TMO_LAST) begin
      if (state == DIV_WAIT && !DivZero && !DivStop) tmo_fire = 1'b1;
      if (state == MULT_WAIT && !MultStop)           tmo_fire = 1'b1;
    end
  end

  // Wait-cycle timer: cleared on operation start, counts every wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (start_div || start_mult) timer <= '0;
      else if (busy)               timer <= timer + 8'd1;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state, register-write and start decisions for the sequencer.
  always_comb begin
    state_d    = state;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = op_a;
    lo_d       = op_a;
    start_div  = 1'b0;
    start_mult = 1'b0;
    exc_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          unique case (op_sel)
            OP_DIV: begin
              if (op_b == '0) begin
                exc_d = 1'b1;
              end else begin
                start_div = 1'b1;
                state_d   = DIV_WAIT;
              end
            end
            OP_MULT: begin
              start_mult = 1'b1;
              state_d    = MULT_WAIT;
            end
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            default: ;
          endcase
        end
      end
      DIV_WAIT: begin
        hi_d = resultHigh;
        lo_d = resultLow;
        if (DivZero) begin
          exc_d   = 1'b1;
          state_d = IDLE;
        end else if (DivStop) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          state_d = IDLE;
        end else if (tmo_fire) begin
          state_d = IDLE;
        end
      end
      MULT_WAIT: begin
        hi_d = multHigh;
        lo_d = multLow;
        if (MultStop) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          state_d = IDLE;
        end else if (tmo_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, start pulses, operand latches and exception pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      DivIn        <= 1'b0;
      MultIn       <= 1'b0;
      arith_a      <= '0;
      arith_b      <= '0;
      div_zero_exc <= 1'b0;
    end else begin
      state        <= state_d;
      DivIn        <= start_div;
      MultIn       <= start_mult;
      div_zero_exc <= exc_d;
      if (start_div || start_mult) begin
        arith_a <= op_a;
        arith_b <= op_b;
      end
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_regs (
    .clk    (clk),
    .rst_n  (rst_n),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_d   (hi_d),
    .lo_d   (lo_d),
    .rd_sel (rd_sel),
    .rd_mux (rd_mux)
  );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl; the bench plays the divider/multiplier.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 40;

  logic         clk;
  logic         rst_n;
  logic         op_valid;
  logic [1:0]   op_sel;
  logic [W-1:0] op_a, op_b;
  logic         rd_en, rd_sel;
  logic [W-1:0] rd_data;
  logic         stall, busy, DivIn, MultIn;
  logic [W-1:0] arith_a, arith_b;
  logic         DivStop, MultStop, DivZero;
  logic [W-1:0] resultHigh, resultLow, multHigh, multLow;
  logic         div_zero_exc, timeout_err;

  int checks = 0;
  int errors = 0;

  // Architectural model of the register file.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  hilo_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
    .stall(stall), .busy(busy), .DivIn(DivIn), .MultIn(MultIn),
    .arith_a(arith_a), .arith_b(arith_b), .DivStop(DivStop), .MultStop(MultStop),
    .DivZero(DivZero), .resultHigh(resultHigh), .resultLow(resultLow),
    .multHigh(multHigh), .multLow(multLow), .div_zero_exc(div_zero_exc),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an op for exactly one accepting edge.
  task automatic issue(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1; op_sel = sel; op_a = a; op_b = b;
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rd_en = 1'b1; rd_sel = 1'b0; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", rd_data); end
    rd_sel = 1'b1; #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({DivIn, MultIn, div_zero_exc, timeout_err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 0000", {DivIn, MultIn, div_zero_exc, timeout_err});
    end
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_div();
    logic [W-1:0] a, b, eh, el;
    int lat, pulses, bad;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin a = 100; b = 7; lat = 33; end
      else begin
        a = $urandom; b = $urandom; if (b == 0) b = 1;
        lat = $urandom_range(1, 20);
      end
      eh = a % b; el = a / b;
      issue(OP_DIV, a, b);
      pulses = DivIn ? 1 : 0;
      bad = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy got %b exp 1", busy); end
      checks++; if (arith_a !== a || arith_b !== b) begin
        errors++; $display("FAIL div_operands got %h/%h exp %h/%h", arith_a, arith_b, a, b);
      end
      rd_en = 1'b1; rd_sel = 1'b0; #1;
      checks++; if (stall !== 1'b1 || rd_data !== '0) begin
        errors++; $display("FAIL div_read_stall got stall %b data %h exp 1/0", stall, rd_data);
      end
      for (int c = 1; c < lat; c++) begin
        step();
        if (DivIn) pulses++;
        if (!stall || !busy) bad++;
      end
      DivStop = 1'b1; resultHigh = eh; resultLow = el; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL div_done_cycle_stall got %b exp 1", stall); end
      step();
      DivStop = 1'b0; resultHigh = $urandom; resultLow = $urandom; #1;
      checks++; if (busy !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("FAIL div_idle got busy %b stall %b exp 0/0", busy, stall);
      end
      checks++; if (rd_data !== el) begin errors++; $display("FAIL div_lo got %h exp %h", rd_data, el); end
      rd_sel = 1'b1; #1;
      checks++; if (rd_data !== eh) begin errors++; $display("FAIL div_hi got %h exp %h", rd_data, eh); end
      checks++; if (pulses != 1 || bad != 0) begin
        errors++; $display("FAIL div_pulse got %0d pulses %0d bad exp 1/0", pulses, bad);
      end
      rd_en = 1'b0;
      m_hi = eh; m_lo = el;
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    issue(OP_DIV, $urandom, '0);
    checks++; if (div_zero_exc !== 1'b1 || DivIn !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dz_pulse got exc %b DivIn %b busy %b exp 1/0/0", div_zero_exc, DivIn, busy);
    end
    step();
    checks++; if (div_zero_exc !== 1'b0) begin errors++; $display("FAIL dz_width got %b exp 0", div_zero_exc); end
    rd_en = 1'b1; rd_sel = 1'b0; #1;
    checks++; if (rd_data !== m_lo) begin errors++; $display("FAIL dz_lo got %h exp %h", rd_data, m_lo); end
    rd_sel = 1'b1; #1;
    checks++; if (rd_data !== m_hi) begin errors++; $display("FAIL dz_hi got %h exp %h", rd_data, m_hi); end
    rd_en = 1'b0;
    // Divider reports divide-by-zero while waiting; results must be discarded.
    issue(OP_DIV, $urandom, 32'd5);
    repeat (3) step();
    DivZero = 1'b1; DivStop = 1'($urandom_range(0, 1));
    resultHigh = $urandom; resultLow = $urandom;
    step();
    DivZero = 1'b0; DivStop = 1'b0;
    checks++; if (div_zero_exc !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dz_wait got exc %b busy %b exp 1/0", div_zero_exc, busy);
    end
    step();
    checks++; if (div_zero_exc !== 1'b0) begin errors++; $display("FAIL dz_wait_width got %b exp 0", div_zero_exc); end
    rd_en = 1'b1; rd_sel = 1'b1; #1;
    checks++; if (rd_data !== m_hi) begin errors++; $display("FAIL dz_wait_hi got %h exp %h", rd_data, m_hi); end
    rd_sel = 1'b0; #1;
    checks++; if (rd_data !== m_lo) begin errors++; $display("FAIL dz_wait_lo got %h exp %h", rd_data, m_lo); end
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, lo_v;
    logic [2*W-1:0] p1, p2;
    int bad, lat;
    issue(OP_MTHI, 32'hDEADBEEF, $urandom);
    rd_en = 1'b1; rd_sel = 1'b1; #1;
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi got %h exp deadbeef", rd_data); end
    rd_en = 1'b0;
    lo_v = $urandom;
    issue(OP_MTLO, lo_v, $urandom);
    rd_en = 1'b1; rd_sel = 1'b0; #1;
    checks++; if (rd_data !== lo_v) begin errors++; $display("FAIL mtlo got %h exp %h", rd_data, lo_v); end
    rd_sel = 1'b1; #1;
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_keeps_hi got %h exp deadbeef", rd_data); end
    rd_en = 1'b0;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    p1 = {32'b0, a1} * {32'b0, b1};
    p2 = {32'b0, a2} * {32'b0, b2};
    issue(OP_MULT, a1, b1);
    checks++; if (MultIn !== 1'b1 || arith_a !== a1 || arith_b !== b1) begin
      errors++; $display("FAIL mult_start got MultIn %b a %h b %h exp 1 %h %h", MultIn, arith_a, arith_b, a1, b1);
    end
    op_valid = 1'b1; op_sel = OP_MULT; op_a = a2; op_b = b2; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mult_second_stall got %b exp 1", stall); end
    bad = 0;
    lat = $urandom_range(2, 15);
    for (int c = 0; c < lat; c++) begin
      DivStop = 1'($urandom_range(0, 1)); DivZero = 1'($urandom_range(0, 1));
      step();
      if (!stall || !busy || MultIn || div_zero_exc) bad++;
    end
    DivStop = 1'b0; DivZero = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL mult_wait_hold got %0d bad cycles exp 0", bad); end
    MultStop = 1'b1; multHigh = p1[63:32]; multLow = p1[31:0];
    step();
    MultStop = 1'b0; multHigh = $urandom; multLow = $urandom;
    rd_en = 1'b1; rd_sel = 1'b1; #1;
    checks++; if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL mult_done got busy %b stall %b exp 0/0", busy, stall);
    end
    checks++; if (rd_data !== p1[63:32]) begin errors++; $display("FAIL mult_hi got %h exp %h", rd_data, p1[63:32]); end
    rd_sel = 1'b0; #1;
    checks++; if (rd_data !== p1[31:0]) begin errors++; $display("FAIL mult_lo got %h exp %h", rd_data, p1[31:0]); end
    step();
    op_valid = 1'b0; rd_en = 1'b0;
    checks++; if (MultIn !== 1'b1 || arith_a !== a2 || arith_b !== b2) begin
      errors++; $display("FAIL mult2_start got MultIn %b a %h b %h exp 1 %h %h", MultIn, arith_a, arith_b, a2, b2);
    end
    repeat (3) step();
    MultStop = 1'b1; multHigh = p2[63:32]; multLow = p2[31:0];
    step();
    MultStop = 1'b0;
    rd_en = 1'b1; rd_sel = 1'b1; #1;
    checks++; if (rd_data !== p2[63:32]) begin errors++; $display("FAIL mult2_hi got %h exp %h", rd_data, p2[63:32]); end
    rd_sel = 1'b0; #1;
    checks++; if (rd_data !== p2[31:0]) begin errors++; $display("FAIL mult2_lo got %h exp %h", rd_data, p2[31:0]); end
    rd_en = 1'b0;
    m_hi = p2[63:32]; m_lo = p2[31:0];
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV, $urandom, 32'd9);
    repeat (9) step();
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || DivIn !== 1'b0 || arith_a !== '0 || arith_b !== '0) begin
      errors++; $display("FAIL rstmid_state got busy %b DivIn %b a %h b %h exp 0", busy, DivIn, arith_a, arith_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    DivStop = 1'b1; resultHigh = $urandom | 32'h1; resultLow = $urandom | 32'h1;
    step();
    DivStop = 1'b0;
    m_hi = '0; m_lo = '0;
    rd_en = 1'b1; rd_sel = 1'b1; #1;
    checks++; if (busy !== 1'b0 || rd_data !== m_hi) begin
      errors++; $display("FAIL rstmid_hi got busy %b data %h exp 0/%h", busy, rd_data, m_hi);
    end
    rd_sel = 1'b0; #1;
    checks++; if (rd_data !== m_lo) begin errors++; $display("FAIL rstmid_lo got %h exp %h", rd_data, m_lo); end
    rd_en = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    logic [W-1:0] eh, el;
    issue(OP_MTHI, 32'h1234_5678, '0);
    issue(OP_MTLO, 32'h9ABC_DEF0, '0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    issue(OP_DIV, $urandom, 32'd3);
    bad = 0;
`ifdef HILO_TIMEOUT_EN
    for (int c = 1; c <= int'(TMO); c++) begin
      if (!busy || timeout_err) bad++;
      if (c < int'(TMO)) step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tmo_early got %0d bad cycles exp 0", bad); end
    step();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_fire got err %b busy %b exp 1/0", timeout_err, busy);
    end
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_width got %b exp 0", timeout_err); end
`else
    for (int c = 0; c < 60; c++) begin
      if (!busy || timeout_err) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL notmo_hold got %0d bad cycles exp 0", bad); end
    eh = 32'd1; el = 32'd7;
    DivStop = 1'b1; resultHigh = eh; resultLow = el;
    step();
    DivStop = 1'b0;
    m_hi = eh; m_lo = el;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL notmo_done got %b exp 0", busy); end
`endif
    rd_en = 1'b1; rd_sel = 1'b1; #1;
    checks++; if (rd_data !== m_hi) begin errors++; $display("FAIL tmo_hi got %h exp %h", rd_data, m_hi); end
    rd_sel = 1'b0; #1;
    checks++; if (rd_data !== m_lo) begin errors++; $display("FAIL tmo_lo got %h exp %h", rd_data, m_lo); end
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_sel = OP_DIV; op_a = '0; op_b = '0;
    rd_en = 1'b0; rd_sel = 1'b0;
    DivStop = 1'b0; MultStop = 1'b0; DivZero = 1'b0;
    resultHigh = '0; resultLow = '0; multHigh = '0; multLow = '0;
    @(negedge clk);
    test_reset();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
